// File: rtl/tx_pkg.sv
// Shared types and constants for the byte transmit sequencer.
// The optional sync prefix is compiled in with TX_SEQ_SYNC_EN.
package tx_pkg;

  localparam int         BYTE_W     = 8;
  localparam logic [7:0] SYNC_BYTE  = 8'h80;
  localparam logic       IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    EOP  = 2'd3
  } tx_seq_state_t;

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load, shift-right register that refills with ones so the line
// settles at its idle level once every data bit has been shifted out.
module tx_shift_reg #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] din,
  output logic              bit0
);

  logic [BYTE_W-1:0] shreg_q;
  logic [BYTE_W-1:0] shreg_d;

  // Next value: load has priority over shift.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      shreg_d = {1'b1, shreg_q[BYTE_W-1:1]};
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Register update with synchronous reset to all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '1;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign bit0 = shreg_q[0];

endmodule

// File: rtl/tx_sequencer.sv
// Byte transmit sequencer: FIFO handshake, LSB-first serialisation, packet
// framing and underrun flag. Define TX_SEQ_SYNC_EN to prefix a sync byte.
module tx_sequencer
  import tx_pkg::*;
#(
  parameter int              BYTE_W    = tx_pkg::BYTE_W,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = tx_pkg::SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  input  logic              shift_enable,
  input  logic              byte_sent,
  output logic              enable_timer,
  output logic              serial_out,
  output logic              busy,
  output logic              packet_done,
  output logic              underrun
);

  localparam int CNT_W = $clog2(BYTE_W);

  tx_seq_state_t    state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             underrun_q, underrun_d;
  logic             gap_first_q, gap_first_d;
  logic             sh_load_s, sh_shift_s, sh_bit0_s;
  logic [BYTE_W-1:0] sh_din_s;
`ifdef TX_SEQ_SYNC_EN
  logic [BYTE_W-1:0] hold_data_q, hold_data_d;
  logic             hold_last_q, hold_last_d;
  logic             sync_pend_q, sync_pend_d;
`endif

  tx_shift_reg #(.BYTE_W(BYTE_W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load_s),
    .shift (sh_shift_s),
    .din   (sh_din_s),
    .bit0  (sh_bit0_s)
  );

  // Next-state, datapath control and flag updates.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    underrun_d  = underrun_q;
    gap_first_d = gap_first_q;
    sh_load_s   = 1'b0;
    sh_shift_s  = 1'b0;
    sh_din_s    = tx_data;
`ifdef TX_SEQ_SYNC_EN
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    sync_pend_d = sync_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          sh_load_s  = 1'b1;
          cnt_d      = '0;
          underrun_d = 1'b0;
          state_d    = SEND;
`ifdef TX_SEQ_SYNC_EN
          // Park the first data byte while the sync prefix goes out.
          hold_data_d = tx_data;
          hold_last_d = tx_last;
          sync_pend_d = 1'b1;
          sh_din_s    = SYNC_BYTE;
          last_d      = 1'b0;
`else
          last_d      = tx_last;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (shift_enable) begin
          sh_shift_s = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end else begin
          sh_shift_s = 1'b0;
        end
        if (byte_sent) begin
          state_d     = last_q ? EOP : GAP;
          gap_first_d = 1'b1;
        end else begin
          state_d = SEND;
        end
      end
      GAP: begin
`ifdef TX_SEQ_SYNC_EN
        if (sync_pend_q) begin
          sh_load_s   = 1'b1;
          sh_din_s    = hold_data_q;
          last_d      = hold_last_q;
          sync_pend_d = 1'b0;
          cnt_d       = '0;
          state_d     = SEND;
        end else
`endif
        if (tx_valid) begin
          sh_load_s = 1'b1;
          last_d    = tx_last;
          cnt_d     = '0;
          state_d   = SEND;
        end else begin
          // The first empty GAP cycle is tolerated; later ones are underrun.
          if (!gap_first_q) begin
            underrun_d = 1'b1;
          end else begin
            underrun_d = underrun_q;
          end
          gap_first_d = 1'b0;
        end
      end
      EOP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      underrun_q  <= 1'b0;
      gap_first_q <= 1'b0;
`ifdef TX_SEQ_SYNC_EN
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      sync_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      underrun_q  <= underrun_d;
      gap_first_q <= gap_first_d;
`ifdef TX_SEQ_SYNC_EN
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      sync_pend_q <= sync_pend_d;
`endif
    end
  end

`ifdef TX_SEQ_SYNC_EN
  assign tx_ready = (state_q == IDLE) || ((state_q == GAP) && !sync_pend_q);
`else
  assign tx_ready = (state_q == IDLE) || (state_q == GAP);
`endif
  assign enable_timer = (state_q == SEND);
  assign serial_out   = (state_q == SEND) ? sh_bit0_s : IDLE_LEVEL;
  assign busy         = (state_q != IDLE);
  assign packet_done  = (state_q == EOP);
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_tx_sequencer.sv
// Directed self-checking bench for tx_sequencer; the timer is modelled at
// 8 clocks per bit. Sync-prefix scenario runs when TX_SEQ_SYNC_EN is defined.
module tb_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       shift_enable;
  logic       byte_sent;
  logic       enable_timer;
  logic       serial_out;
  logic       busy;
  logic       packet_done;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  tx_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .shift_enable (shift_enable),
    .byte_sent    (byte_sent),
    .enable_timer (enable_timer),
    .serial_out   (serial_out),
    .busy         (busy),
    .packet_done  (packet_done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Timer stand-in for one byte, entered on the first SEND cycle; collects the
  // sampled bits and counts hold/enable violations. Returns one cycle after
  // the byte_sent edge.
  task automatic run_byte(input bit coincide, output logic [7:0] got, output int bad);
    logic prev;
    bad  = 0;
    got  = 8'h00;
    prev = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 8; c++) begin
        if (c == 0) begin
          got[b] = serial_out;
          prev   = serial_out;
        end else if (serial_out !== prev) begin
          bad++;
        end
        if (enable_timer !== 1'b1) bad++;
        shift_enable = (c == 7);
        byte_sent    = coincide && (b == 7) && (c == 7);
        @(negedge clk);
      end
    end
    if (!coincide) begin
      if (serial_out !== 1'b1 || enable_timer !== 1'b1) bad++;
      shift_enable = 1'b0;
      byte_sent    = 1'b1;
      @(negedge clk);
    end
    shift_enable = 1'b0;
    byte_sent    = 1'b0;
  endtask

  task automatic accept(input logic [7:0] d, input logic last);
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    shift_enable = 1'b0; byte_sent = 1'b0;
    repeat (2) @(negedge clk);
    // Handshake coincident with reset must be dropped.
    tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1;
    @(negedge clk);
    rst = 1'b0; tx_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_handshake_busy: got %b exp 0", busy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b exp 1", tx_ready); end
    checks++; if (enable_timer !== 1'b0) begin errors++; $display("FAIL reset_enable_timer: got %b exp 0", enable_timer); end
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_serial_out: got %b exp 1", serial_out); end
    checks++; if (packet_done !== 1'b0) begin errors++; $display("FAIL reset_packet_done: got %b exp 0", packet_done); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b exp 0", underrun); end
  endtask

  task automatic test_single_byte;
    logic [7:0] got; int bad;
    accept(8'hA5, 1'b1);
    run_byte(1'b0, got, bad);
    checks++; if (got !== 8'hA5) begin errors++; $display("FAIL single_bits: got %h exp a5", got); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_hold: got %0d violations exp 0", bad); end
    checks++; if (packet_done !== 1'b1) begin errors++; $display("FAIL single_packet_done: got %b exp 1", packet_done); end
    checks++; if (enable_timer !== 1'b0) begin errors++; $display("FAIL single_eop_timer: got %b exp 0", enable_timer); end
    @(negedge clk);
    checks++; if (packet_done !== 1'b0) begin errors++; $display("FAIL single_pd_width: got %b exp 0", packet_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b exp 0", busy); end
  endtask

  task automatic test_two_byte;
    logic [7:0] got; int bad;
    tx_data = 8'h3C; tx_last = 1'b0; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF; tx_last = 1'b1;
    run_byte(1'b0, got, bad);
    checks++; if (got !== 8'h3C || bad !== 0) begin errors++; $display("FAIL two_byte0: got %h/%0d exp 3c/0", got, bad); end
    checks++; if (tx_ready !== 1'b1 || serial_out !== 1'b1) begin errors++; $display("FAIL two_gap_lines: got ready=%b ser=%b exp 1/1", tx_ready, serial_out); end
    checks++; if (enable_timer !== 1'b0 || packet_done !== 1'b0) begin errors++; $display("FAIL two_gap_timer: got en=%b pd=%b exp 0/0", enable_timer, packet_done); end
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (enable_timer !== 1'b1) begin errors++; $display("FAIL two_gap_one_cycle: got en=%b exp 1", enable_timer); end
    run_byte(1'b0, got, bad);
    checks++; if (got !== 8'hFF || bad !== 0) begin errors++; $display("FAIL two_byte1: got %h/%0d exp ff/0", got, bad); end
    checks++; if (packet_done !== 1'b1) begin errors++; $display("FAIL two_packet_done: got %b exp 1", packet_done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || packet_done !== 1'b0) begin errors++; $display("FAIL two_idle: got busy=%b pd=%b exp 0/0", busy, packet_done); end
  endtask

  task automatic test_underrun;
    logic [7:0] got; int bad;
    accept(8'h3C, 1'b0);
    run_byte(1'b0, got, bad);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_gap1: got %b exp 0", underrun); end
    repeat (2) @(negedge clk);
    checks++; if (underrun !== 1'b1 || tx_ready !== 1'b1) begin errors++; $display("FAIL underrun_gap3: got ur=%b ready=%b exp 1/1", underrun, tx_ready); end
    repeat (3) @(negedge clk);
    accept(8'hFF, 1'b1);
    run_byte(1'b0, got, bad);
    checks++; if (got !== 8'hFF || bad !== 0) begin errors++; $display("FAIL underrun_late_byte: got %h/%0d exp ff/0", got, bad); end
    checks++; if (packet_done !== 1'b1 || underrun !== 1'b1) begin errors++; $display("FAIL underrun_eop: got pd=%b ur=%b exp 1/1", packet_done, underrun); end
    @(negedge clk);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b exp 1", underrun); end
    accept(8'h81, 1'b1);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b exp 0", underrun); end
    run_byte(1'b0, got, bad);
    checks++; if (got !== 8'h81 || bad !== 0) begin errors++; $display("FAIL underrun_next_byte: got %h/%0d exp 81/0", got, bad); end
    @(negedge clk);
  endtask

  task automatic test_coincide;
    logic [7:0] got; int bad;
    accept(8'h5A, 1'b0);
    run_byte(1'b1, got, bad);
    checks++; if (got !== 8'h5A || bad !== 0) begin errors++; $display("FAIL coincide_bits: got %h/%0d exp 5a/0", got, bad); end
    checks++; if (enable_timer !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("FAIL coincide_gap: got en=%b ready=%b exp 0/1", enable_timer, tx_ready); end
    checks++; if (serial_out !== 1'b1 || packet_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL coincide_lines: got ser=%b pd=%b busy=%b exp 1/0/1", serial_out, packet_done, busy); end
  endtask

  task automatic test_reset_mid;
    int pd_seen;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    accept(8'hC3, 1'b1);
    for (int i = 0; i < 24; i++) begin
      shift_enable = ((i % 8) == 7);
      @(negedge clk);
    end
    shift_enable = 1'b0;
    checks++; if (serial_out !== 1'b0 || enable_timer !== 1'b1) begin errors++; $display("FAIL midreset_bit3: got ser=%b en=%b exp 0/1", serial_out, enable_timer); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (serial_out !== 1'b1 || enable_timer !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("FAIL midreset_lines: got ser=%b en=%b ready=%b exp 1/0/1", serial_out, enable_timer, tx_ready); end
    pd_seen = 0;
    for (int i = 0; i < 12; i++) begin
      byte_sent = (i == 3);
      if (packet_done === 1'b1) pd_seen++;
      @(negedge clk);
    end
    byte_sent = 1'b0;
    checks++; if (pd_seen !== 0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_no_pd: got pd=%0d busy=%b exp 0/0", pd_seen, busy); end
  endtask

`ifdef TX_SEQ_SYNC_EN
  task automatic test_sync;
    logic [7:0] got; int bad;
    accept(8'h01, 1'b1);
    run_byte(1'b0, got, bad);
    checks++; if (got !== 8'h80 || bad !== 0) begin errors++; $display("FAIL sync_prefix: got %h/%0d exp 80/0", got, bad); end
    checks++; if (tx_ready !== 1'b0 || serial_out !== 1'b1 || enable_timer !== 1'b0) begin errors++; $display("FAIL sync_gap: got ready=%b ser=%b en=%b exp 0/1/0", tx_ready, serial_out, enable_timer); end
    @(negedge clk);
    run_byte(1'b0, got, bad);
    checks++; if (got !== 8'h01 || bad !== 0) begin errors++; $display("FAIL sync_data: got %h/%0d exp 01/0", got, bad); end
    checks++; if (packet_done !== 1'b1) begin errors++; $display("FAIL sync_packet_done: got %b exp 1", packet_done); end
    @(negedge clk);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
`ifdef TX_SEQ_SYNC_EN
    test_sync();
`else
    test_single_byte();
    test_two_byte();
    test_underrun();
    test_coincide();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
